// File: rtl/scratch_arbiter.sv
// scratch_arbiter: arbitrates the single-port scratch RAM between stage2
// stores (always win), stage1 reads and the host port. A saturating starve
// counter lets a waiting host outrank stage1 after STARVE_LIMIT denials.
// Optional feature macro: SCRATCH_ARB_BYPASS_EN (forward a same-address s2
// store directly to a colliding s1 read).
module scratch_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s2_wr_en,
    input  logic [ADDR_WIDTH-1:0] s2_wr_addr,
    input  logic [DATA_WIDTH-1:0] s2_wr_data,
    input  logic                  s1_rd_req,
    input  logic [ADDR_WIDTH-1:0] s1_rd_addr,
    output logic                  s1_rd_gnt,
    output logic                  s1_rd_vld,
    output logic [DATA_WIDTH-1:0] s1_rd_data,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rd_vld,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_S1   = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] r_starve_cnt;
    logic [7:0] w_starve_nxt;
    owner_t     r_owner;
    owner_t     w_owner_nxt;
    logic       w_host_urgent;
    logic       w_byp_hit;
    // Winners before reset gating; only the outputs see rst, the flops
    // are held by their asynchronous clear instead.
    logic       w_s1_win;
    logic       w_host_win;

`ifdef SCRATCH_ARB_BYPASS_EN
    logic                  r_byp_flag;
    logic [DATA_WIDTH-1:0] r_byp_data;
    assign w_byp_hit = s2_wr_en && s1_rd_req && (s2_wr_addr == s1_rd_addr);
`else
    assign w_byp_hit = 1'b0;
`endif

    assign w_host_urgent = host_req && (r_starve_cnt == LIMIT);

    // Fixed priority: s2 store, starved host, s1 read, host.
    always_comb begin
        w_s1_win   = 1'b0;
        w_host_win = 1'b0;
        if (s2_wr_en) begin
            w_s1_win = w_byp_hit;
        end else if (w_host_urgent) begin
            w_host_win = 1'b1;
        end else if (s1_rd_req) begin
            w_s1_win = 1'b1;
        end else if (host_req) begin
            w_host_win = 1'b1;
        end
    end

    assign s1_rd_gnt = rst && w_s1_win;
    assign host_gnt  = rst && w_host_win;

    // RAM port mux; a bypassed s1 read never touches the RAM, the store does.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst) begin
            if (s2_wr_en) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = s2_wr_addr;
                mem_wdata = s2_wr_data;
            end else if (w_host_win) begin
                mem_en    = 1'b1;
                mem_we    = host_we;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
            end else if (w_s1_win) begin
                mem_en    = 1'b1;
                mem_addr  = s1_rd_addr;
            end
        end
    end

    // Next starve count and next read-return owner.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        w_owner_nxt  = OWN_NONE;
        if (w_host_win || !host_req) begin
            w_starve_nxt = 8'd0;
        end else if (r_starve_cnt != LIMIT) begin
            w_starve_nxt = r_starve_cnt + 8'd1;
        end
        if (w_s1_win) begin
            w_owner_nxt = OWN_S1;
        end else if (w_host_win && !host_we) begin
            w_owner_nxt = OWN_HOST;
        end
    end

    // Starve counter and return owner; reset drops any pending return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= 8'd0;
            r_owner      <= OWN_NONE;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            r_owner      <= w_owner_nxt;
        end
    end

    assign s1_rd_vld   = (r_owner == OWN_S1);
    assign host_rd_vld = (r_owner == OWN_HOST);
    assign host_rdata  = mem_rdata;

`ifdef SCRATCH_ARB_BYPASS_EN
    // Capture the colliding store data so s1 sees it next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byp_flag <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_byp_flag <= w_byp_hit;
            if (w_byp_hit) begin
                r_byp_data <= s2_wr_data;
            end
        end
    end

    assign s1_rd_data = r_byp_flag ? r_byp_data : mem_rdata;
`else
    assign s1_rd_data = mem_rdata;
`endif

endmodule

// File: tb/tb_scratch_arbiter.sv
// Self-checking bench for scratch_arbiter: directed scenarios plus a
// randomized run checked against a cycle-level behavioural model.
module tb_scratch_arbiter;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s2_wr_en;
    logic [AW-1:0] s2_wr_addr;
    logic [DW-1:0] s2_wr_data;
    logic          s1_rd_req;
    logic [AW-1:0] s1_rd_addr;
    logic          s1_rd_gnt;
    logic          s1_rd_vld;
    logic [DW-1:0] s1_rd_data;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          host_rd_vld;
    logic [DW-1:0] host_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    scratch_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .s2_wr_en(s2_wr_en), .s2_wr_addr(s2_wr_addr), .s2_wr_data(s2_wr_data),
        .s1_rd_req(s1_rd_req), .s1_rd_addr(s1_rd_addr), .s1_rd_gnt(s1_rd_gnt),
        .s1_rd_vld(s1_rd_vld), .s1_rd_data(s1_rd_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rd_vld(host_rd_vld),
        .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Scratch RAM with 1-cycle read latency.
    logic [DW-1:0] ram [16];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // ---------------- behavioural model state ----------------
    logic [DW-1:0] gmem [16];
    int            wait_cnt;
    logic          m_s1_gnt, m_host_gnt, m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          cur_s1_vld, cur_host_vld, nxt_s1_vld, nxt_host_vld;
    logic [DW-1:0] cur_s1_data, cur_host_data, nxt_s1_data, nxt_host_data;

    // Decide who owns the RAM this cycle from the priority rules.
    task automatic model_eval();
        logic urgent;
        urgent     = host_req && (wait_cnt >= SL);
        m_s1_gnt   = 1'b0;
        m_host_gnt = 1'b0;
        if (s2_wr_en) begin
`ifdef SCRATCH_ARB_BYPASS_EN
            m_s1_gnt = s1_rd_req && (s1_rd_addr == s2_wr_addr);
`endif
        end else if (urgent)    m_host_gnt = 1'b1;
        else if (s1_rd_req)     m_s1_gnt   = 1'b1;
        else if (host_req)      m_host_gnt = 1'b1;
        m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        if (s2_wr_en) begin
            m_en = 1'b1; m_we = 1'b1; m_addr = s2_wr_addr; m_wdata = s2_wr_data;
        end else if (m_host_gnt) begin
            m_en = 1'b1; m_we = host_we; m_addr = host_addr; m_wdata = host_wdata;
        end else if (m_s1_gnt) begin
            m_en = 1'b1; m_addr = s1_rd_addr;
        end
        nxt_s1_vld   = m_s1_gnt;
        nxt_s1_data  = s2_wr_en ? s2_wr_data : gmem[s1_rd_addr];
        nxt_host_vld = m_host_gnt && !host_we;
        nxt_host_data = gmem[host_addr];
    endtask

    // Apply this cycle's writes and advance to the next cycle.
    task automatic model_commit();
        if (s2_wr_en) gmem[s2_wr_addr] = s2_wr_data;
        if (m_host_gnt && host_we) gmem[host_addr] = host_wdata;
        wait_cnt      = (host_req && !m_host_gnt) ? wait_cnt + 1 : 0;
        cur_s1_vld    = nxt_s1_vld;
        cur_s1_data   = nxt_s1_data;
        cur_host_vld  = nxt_host_vld;
        cur_host_data = nxt_host_data;
    endtask

    task automatic idle_inputs();
        s2_wr_en = 1'b0; s2_wr_addr = '0; s2_wr_data = '0;
        s1_rd_req = 1'b0; s1_rd_addr = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        s1_rd_req = 1'b1; host_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vec_cnt++; if (s1_rd_gnt !== 1'b0 || host_gnt !== 1'b0) begin err_cnt++;
            $display("FAIL rst_gnt: got s1=%b host=%b want 0", s1_rd_gnt, host_gnt); end
        vec_cnt++; if (mem_en !== 1'b0) begin err_cnt++;
            $display("FAIL rst_mem_en: got %b want 0", mem_en); end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        vec_cnt++; if ({s1_rd_vld, host_rd_vld, s1_rd_gnt, host_gnt, mem_en} !== 5'b0) begin err_cnt++;
            $display("FAIL idle_after_rst: got %b want 00000",
                     {s1_rd_vld, host_rd_vld, s1_rd_gnt, host_gnt, mem_en}); end
        // reset asserted with an s1 read in flight
        @(negedge clk);
        s1_rd_req = 1'b1; s1_rd_addr = 4'd3;
        #1;
        vec_cnt++; if (s1_rd_gnt !== 1'b1) begin err_cnt++;
            $display("FAIL midrd_gnt: got %b want 1", s1_rd_gnt); end
        @(posedge clk);
        #2 rst = 1'b0;
        s1_rd_req = 1'b0;
        #1;
        vec_cnt++; if (s1_rd_vld !== 1'b0) begin err_cnt++;
            $display("FAIL midrd_kill: got %b want 0", s1_rd_vld); end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            #1;
            vec_cnt++; if (s1_rd_vld !== 1'b0 || host_rd_vld !== 1'b0) begin err_cnt++;
                $display("FAIL post_rst_vld: got s1=%b host=%b want 0", s1_rd_vld, host_rd_vld); end
            @(negedge clk);
        end
    endtask

    task automatic test_s1_read();
        idle_inputs();
        s2_wr_en = 1'b1; s2_wr_addr = 4'd3; s2_wr_data = 32'hDEADBEEF;
        @(negedge clk);
        idle_inputs();
        s1_rd_req = 1'b1; s1_rd_addr = 4'd3;
        #1;
        vec_cnt++; if ({s1_rd_gnt, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 4'd3}) begin err_cnt++;
            $display("FAIL s1_issue: got gnt=%b en=%b we=%b addr=%h want 1 1 0 3",
                     s1_rd_gnt, mem_en, mem_we, mem_addr); end
        vec_cnt++; if (s1_rd_vld !== 1'b0) begin err_cnt++;
            $display("FAIL s1_early_vld: got %b want 0", s1_rd_vld); end
        @(negedge clk);
        s1_rd_req = 1'b0;
        #1;
        vec_cnt++; if (s1_rd_vld !== 1'b1 || s1_rd_data !== 32'hDEADBEEF) begin err_cnt++;
            $display("FAIL s1_ret: got vld=%b data=%h want 1 deadbeef", s1_rd_vld, s1_rd_data); end
        @(negedge clk);
        #1;
        vec_cnt++; if (s1_rd_vld !== 1'b0) begin err_cnt++;
            $display("FAIL s1_vld_one_cycle: got %b want 0", s1_rd_vld); end
        @(negedge clk);
    endtask

    task automatic test_collision();
        idle_inputs();
        s2_wr_en = 1'b1; s2_wr_addr = 4'd5; s2_wr_data = 32'h12345678;
        s1_rd_req = 1'b1; s1_rd_addr = 4'd5;
        #1;
        vec_cnt++; if (mem_we !== 1'b1 || mem_wdata !== 32'h12345678) begin err_cnt++;
            $display("FAIL col_write: got we=%b data=%h want 1 12345678", mem_we, mem_wdata); end
`ifdef SCRATCH_ARB_BYPASS_EN
        vec_cnt++; if (s1_rd_gnt !== 1'b1) begin err_cnt++;
            $display("FAIL col_gnt: got %b want 1", s1_rd_gnt); end
        @(negedge clk);
        idle_inputs();
        #1;
        vec_cnt++; if (s1_rd_vld !== 1'b1 || s1_rd_data !== 32'h12345678) begin err_cnt++;
            $display("FAIL col_byp: got vld=%b data=%h want 1 12345678", s1_rd_vld, s1_rd_data); end
`else
        vec_cnt++; if (s1_rd_gnt !== 1'b0) begin err_cnt++;
            $display("FAIL col_gnt: got %b want 0", s1_rd_gnt); end
        @(negedge clk);
        s2_wr_en = 1'b0;
        #1;
        vec_cnt++; if (s1_rd_gnt !== 1'b1 || s1_rd_vld !== 1'b0) begin err_cnt++;
            $display("FAIL col_retry: got gnt=%b vld=%b want 1 0", s1_rd_gnt, s1_rd_vld); end
        @(negedge clk);
        idle_inputs();
        #1;
        vec_cnt++; if (s1_rd_vld !== 1'b1 || s1_rd_data !== 32'h12345678) begin err_cnt++;
            $display("FAIL col_raw: got vld=%b data=%h want 1 12345678", s1_rd_vld, s1_rd_data); end
`endif
        @(negedge clk);
    endtask

    task automatic test_starve();
        idle_inputs();
        s1_rd_req = 1'b1; s1_rd_addr = 4'd1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 4'd3;
        for (int round = 0; round < 2; round++) begin
            for (int c = 1; c <= SL; c++) begin
                #1;
                vec_cnt++; if (s1_rd_gnt !== 1'b1 || host_gnt !== 1'b0) begin err_cnt++;
                    $display("FAIL starve_wait r%0d c%0d: got s1=%b host=%b want 1 0",
                             round, c, s1_rd_gnt, host_gnt); end
                @(negedge clk);
            end
            #1;
            vec_cnt++; if (s1_rd_gnt !== 1'b0 || host_gnt !== 1'b1) begin err_cnt++;
                $display("FAIL starve_win r%0d: got s1=%b host=%b want 0 1", round, s1_rd_gnt, host_gnt); end
            @(negedge clk);
            #1;
            vec_cnt++; if (host_rd_vld !== 1'b1 || host_rdata !== 32'hDEADBEEF) begin err_cnt++;
                $display("FAIL starve_ret r%0d: got vld=%b data=%h want 1 deadbeef",
                         round, host_rd_vld, host_rdata); end
            #0;
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_host_rw();
        idle_inputs();
        host_req = 1'b1; host_we = 1'b1; host_addr = 4'd9; host_wdata = 32'hA5A5A5A5;
        #1;
        vec_cnt++; if ({host_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 4'd9, 32'hA5A5A5A5}) begin
            err_cnt++;
            $display("FAIL host_wr: got gnt=%b en=%b we=%b addr=%h data=%h",
                     host_gnt, mem_en, mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
        host_we = 1'b0;
        #1;
        vec_cnt++; if (host_rd_vld !== 1'b0) begin err_cnt++;
            $display("FAIL host_wr_novld: got %b want 0", host_rd_vld); end
        vec_cnt++; if (host_gnt !== 1'b1 || mem_we !== 1'b0) begin err_cnt++;
            $display("FAIL host_rd_issue: got gnt=%b we=%b want 1 0", host_gnt, mem_we); end
        @(negedge clk);
        idle_inputs();
        #1;
        vec_cnt++; if (host_rd_vld !== 1'b1 || host_rdata !== 32'hA5A5A5A5) begin err_cnt++;
            $display("FAIL host_rd: got vld=%b data=%h want 1 a5a5a5a5", host_rd_vld, host_rdata); end
        @(negedge clk);
    endtask

    task automatic test_s2_flood();
        idle_inputs();
        host_req = 1'b1; host_addr = 4'd7;
        for (int c = 0; c < 3 * SL; c++) begin
            s2_wr_en = 1'b1; s2_wr_addr = 4'($urandom_range(0, 15)); s2_wr_data = $urandom;
            #1;
            vec_cnt++; if ({host_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b011, s2_wr_addr, s2_wr_data}) begin
                err_cnt++;
                $display("FAIL flood c%0d: got hgnt=%b en=%b we=%b addr=%h data=%h",
                         c, host_gnt, mem_en, mem_we, mem_addr, mem_wdata); end
            @(negedge clk);
        end
        // host is saturated, so it beats a fresh s1 request as soon as s2 stops
        s2_wr_en = 1'b0; s1_rd_req = 1'b1;
        #1;
        vec_cnt++; if (host_gnt !== 1'b1 || s1_rd_gnt !== 1'b0) begin err_cnt++;
            $display("FAIL flood_release: got host=%b s1=%b want 1 0", host_gnt, s1_rd_gnt); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_random();
        idle_inputs();
        @(negedge clk);
        for (int i = 0; i < 16; i++) gmem[i] = ram[i];
        wait_cnt = 0; m_s1_gnt = 1'b0; m_host_gnt = 1'b0;
        cur_s1_vld = 1'b0; cur_host_vld = 1'b0;
        cur_s1_data = '0; cur_host_data = '0;
        for (int n = 0; n < 600; n++) begin
            s2_wr_en   = ($urandom_range(0, 9) < 3);
            s2_wr_addr = 4'($urandom_range(0, 7));
            s2_wr_data = $urandom;
            if (!(s1_rd_req && !m_s1_gnt) || $urandom_range(0, 9) == 0) begin
                s1_rd_req  = $urandom_range(0, 1) == 1;
                s1_rd_addr = 4'($urandom_range(0, 7));
            end
            if (!(host_req && !m_host_gnt)) begin
                host_req   = ($urandom_range(0, 9) < 4);
                host_we    = $urandom_range(0, 1) == 1;
                host_addr  = 4'($urandom_range(0, 7));
                host_wdata = $urandom;
            end
            #1;
            model_eval();
            vec_cnt++; if (s1_rd_gnt !== m_s1_gnt || host_gnt !== m_host_gnt) begin err_cnt++;
                $display("FAIL rnd_gnt n%0d: got s1=%b host=%b want %b %b",
                         n, s1_rd_gnt, host_gnt, m_s1_gnt, m_host_gnt); end
            vec_cnt++; if (mem_en !== m_en) begin err_cnt++;
                $display("FAIL rnd_en n%0d: got %b want %b", n, mem_en, m_en); end
            if (m_en) begin
                vec_cnt++; if (mem_we !== m_we || mem_addr !== m_addr || (m_we && mem_wdata !== m_wdata)) begin
                    err_cnt++;
                    $display("FAIL rnd_port n%0d: got we=%b addr=%h data=%h want %b %h %h",
                             n, mem_we, mem_addr, mem_wdata, m_we, m_addr, m_wdata); end
            end
            vec_cnt++; if (s1_rd_vld !== cur_s1_vld || host_rd_vld !== cur_host_vld) begin err_cnt++;
                $display("FAIL rnd_vld n%0d: got s1=%b host=%b want %b %b",
                         n, s1_rd_vld, host_rd_vld, cur_s1_vld, cur_host_vld); end
            if (cur_s1_vld) begin
                vec_cnt++; if (s1_rd_data !== cur_s1_data) begin err_cnt++;
                    $display("FAIL rnd_s1_data n%0d: got %h want %h", n, s1_rd_data, cur_s1_data); end
            end
            if (cur_host_vld) begin
                vec_cnt++; if (host_rdata !== cur_host_data) begin err_cnt++;
                    $display("FAIL rnd_host_data n%0d: got %h want %h", n, host_rdata, cur_host_data); end
            end
            model_commit();
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_s1_read();
        test_collision();
        test_starve();
        test_host_rw();
        test_s2_flood();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/scratch_arbiter.md
# scratch_arbiter

Arbitrates the single-port scratch register RAM between three requesters: stage2 writeback (stores), stage1 operand reads, and a host configuration/debug port. Stage2 writes always win because stage2 has no backpressure on its scratch path. Stage1 and the host share the remaining cycles, with an anti-starvation counter that guarantees host progress. It sits between the controller stages and the datapath scratch RAM, which has a 1-cycle read latency.

## Interface
- DATA_WIDTH, 32, scratch word width
- ADDR_WIDTH, 4, scratch address width (16 entries)
- STARVE_LIMIT, 4, consecutive denied host cycles before the host outranks stage1; legal range 1..255
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  reset, asynchronous, active-low
- s2_wr_en  in  1  stage2 store request; already gated with valid/ready by stage2
- s2_wr_addr  in  ADDR_WIDTH  store address
- s2_wr_data  in  DATA_WIDTH  store data
- s1_rd_req  in  1  stage1 read request; held until granted
- s1_rd_addr  in  ADDR_WIDTH  read address
- s1_rd_gnt  out  1  combinational grant to stage1
- s1_rd_vld  out  1  registered; read data valid
- s1_rd_data  out  DATA_WIDTH  read data, meaningful only while s1_rd_vld
- host_req  in  1  host access request; held with all host fields stable until granted
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_WIDTH  host address
- host_wdata  in  DATA_WIDTH  host write data
- host_gnt  out  1  combinational grant to host
- host_rd_vld  out  1  registered; host read data valid
- host_rdata  out  DATA_WIDTH  host read data
- mem_en, mem_we  out  1 each  RAM enable and write enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after a read enable

## Operation
- Priority each cycle:
  1. s2_wr_en.
  2. Host, if starve_cnt == STARVE_LIMIT.
  3. s1_rd_req.
  4. host_req.
- Exactly one requester drives the RAM per cycle. Grants are zero while rst is low.
- An s2 write drives mem_en=1, mem_we=1 with s2 addr/data. There is no grant output for stage2; the write is implicit.
- A granted s1 read drives mem_en=1, mem_we=0.
- A granted host access drives mem_we=host_we.
- Idle cycle: mem_en=0, all grants 0.
- starve_cnt, 8 bits:
  - Cleared when host_gnt=1 or host_req=0.
  - Otherwise incremented when host_req=1 and host_gnt=0.
  - Saturates at STARVE_LIMIT.
- Return-owner register rd_owner ∈ {NONE, S1, HOST}, loaded every cycle:
  - S1 when an s1 read is granted.
  - HOST when a host read is granted.
  - NONE otherwise, including all writes.
- In the cycle after the grant: s1_rd_vld = (rd_owner==S1) and host_rd_vld = (rd_owner==HOST).
- s1_rd_data and host_rdata both mirror mem_rdata (or the bypass register, see Configuration).
- Read-after-write through the RAM is naturally ordered: a write at edge N is visible to a read granted at cycle N+1 or later.

## Timing
- Reset (rst low, asynchronous): s1_rd_vld=0, host_rd_vld=0, rd_owner=NONE, starve_cnt=0, bypass register=0. Combinational outputs are forced idle: mem_en=0, grants=0.
- Reset asserted mid-read kills the pending return; no vld pulse follows reset release.
- Read latency: grant in cycle N, rd_vld high for exactly one cycle in N+1.
- A requester may re-request in N+1 and be granted back-to-back, giving an II of 1.
- Requests are level-held. Dropping a request before its grant is legal and has no side effect.
- Same-cycle s2 write and s1 read to any address: s1 is denied and retries (unless bypass is enabled).
- Worst-case host wait under continuous s1 and no s2 traffic: STARVE_LIMIT+1 cycles. Continuous s2 writes can starve the host indefinitely; this is by design.

## Configuration
- SCRATCH_ARB_BYPASS_EN defined: when s2_wr_en and s1_rd_req occur in the same cycle with equal addresses:
  - s1_rd_gnt=1.
  - s2_wr_data is captured into the bypass register.
  - rd_owner=S1 with a bypass flag set.
  - Next cycle: s1_rd_vld=1, s1_rd_data = bypass register.
  - The RAM still performs the s2 write.
  - Different addresses: s1 is denied as normal.
- Undefined: no bypass register. s1 is always denied during an s2 write, and s1_rd_data always equals mem_rdata.

## Test plan
- Reset release, no requests: all outputs 0, mem_en=0. Assert rst low mid-read: no rd_vld pulse afterward.
- s1_rd_req addr 3 alone at cycle N, RAM[3]=0xDEADBEEF: s1_rd_gnt in N, s1_rd_vld and data 0xDEADBEEF in N+1 only.
- s2 write addr 5 = 0x12345678 with s1 read addr 5 in the same cycle:
  - Without bypass: s1 granted one cycle later and reads 0x12345678.
  - With SCRATCH_ARB_BYPASS_EN: granted the same cycle, data 0x12345678 next cycle.
- Continuous s1_rd_req plus host_req, STARVE_LIMIT=4: host_gnt on the 5th cycle, s1_rd_gnt=0 that cycle, starve_cnt then clears.
- Host write addr 9 = 0xA5A5A5A5, then host read addr 9: host_rd_vld with 0xA5A5A5A5. No host_rd_vld after the write.
- s2_wr_en held high with host starve_cnt saturated: host_gnt stays 0, and every cycle is an s2 write.
